fpu_issue_ctrl: RTL and testbench

//  Issue side of the FPU result path: accepts one decoded FP op (op_sel_F encoding) from EX,

---
 rtl/fpu_issue_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - FPU issue controller: dispatches one FP op to its unit and returns the result
module fpu_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [31:0] req_c,
    input  logic [4:0]  req_rd,
    output logic [5:0]  unit_start,
    output logic [4:0]  unit_op,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic [5:0]  unit_done,
    input  logic [31:0] add_res,
    input  logic [31:0] mul_res,
    input  logic [31:0] sgnj_res,
    input  logic [31:0] cvt_res,
    input  logic [31:0] class_res,
    input  logic [31:0] cmp_res,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_illegal,
    output logic        rsp_timeout,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [5:0] U_ADD   = 6'b000001;
    localparam logic [5:0] U_MUL   = 6'b000010;
    localparam logic [5:0] U_SGNJ  = 6'b000100;
    localparam logic [5:0] U_CVT   = 6'b001000;
    localparam logic [5:0] U_CLASS = 6'b010000;
    localparam logic [5:0] U_CMP   = 6'b100000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ISSUE2,
        S_WAIT2,
        S_RESP
    } state_t;

    state_t        state;
    logic [5:0]    sel_q;
    logic          fused_q;
    logic          fmsub_q;
    logic [31:0]   c_q;
    logic [CW-1:0] cnt;

    logic [5:0]    dec_sel;
    logic          dec_fused;
    logic [31:0]   sel_result;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // Map the incoming op code to its owning unit; zero select means illegal
    always_comb begin
        dec_sel   = 6'b000000;
        dec_fused = 1'b0;
        case (req_op)
            5'b01010, 5'b01011:                     dec_sel = U_ADD;
            5'b01100, 5'b01101:                     dec_sel = U_MUL;
            5'b10001, 5'b10010, 5'b10011:           dec_sel = U_SGNJ;
            5'b10110, 5'b10111, 5'b11001, 5'b11010: dec_sel = U_CVT;
            5'b11000:                               dec_sel = U_CLASS;
            5'b10100, 5'b10101, 5'b11011,
            5'b11100, 5'b11101:                     dec_sel = U_CMP;
            5'b11110, 5'b11111: begin
                dec_sel   = U_MUL;
                dec_fused = 1'b1;
            end
            default: begin
                dec_sel   = 6'b000000;
                dec_fused = 1'b0;
            end
        endcase
    end

    // Pick the result bus of the unit that owns the op in flight
    always_comb begin
        sel_result = 32'h0;
        if (sel_q[0]) sel_result = add_res;
        if (sel_q[1]) sel_result = mul_res;
        if (sel_q[2]) sel_result = sgnj_res;
        if (sel_q[3]) sel_result = cvt_res;
        if (sel_q[4]) sel_result = class_res;
        if (sel_q[5]) sel_result = cmp_res;
    end

    // Issue FSM with registered unit and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            unit_start  <= 6'b000000;
            unit_op     <= 5'b00000;
            unit_a      <= 32'h0;
            unit_b      <= 32'h0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 32'h0;
            rsp_rd      <= 5'b00000;
            rsp_illegal <= 1'b0;
            rsp_timeout <= 1'b0;
            sel_q       <= 6'b000000;
            fused_q     <= 1'b0;
            fmsub_q     <= 1'b0;
            c_q         <= 32'h0;
            cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        rsp_rd      <= req_rd;
                        rsp_illegal <= 1'b0;
                        rsp_timeout <= 1'b0;
                        c_q         <= req_c;
                        sel_q       <= dec_sel;
                        fused_q     <= dec_fused;
                        fmsub_q     <= req_op[0];
                        if (dec_sel == 6'b000000) begin
                            state       <= S_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_data    <= 32'h0;
                            rsp_illegal <= 1'b1;
                        end else begin
                            state      <= S_ISSUE;
                            unit_start <= dec_sel;
                            unit_op    <= dec_fused ? 5'b01100 : req_op;
                            unit_a     <= req_a;
                            unit_b     <= req_b;
                        end
                    end
                end
                S_ISSUE: begin
                    unit_start <= 6'b000000;
                    cnt        <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (|(unit_done & sel_q)) begin
                        if (fused_q) begin
                            state   <= S_ISSUE2;
                            unit_op <= fmsub_q ? 5'b01011 : 5'b01010;
                            unit_a  <= mul_res;
                            unit_b  <= c_q;
                        end else begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= sel_result;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state       <= S_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= 32'h0;
                        rsp_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Product operands are registered first; the ADD start follows one cycle later
                S_ISSUE2: begin
                    if (unit_start[0]) begin
                        unit_start <= 6'b000000;
                        cnt        <= '0;
                        state      <= S_WAIT2;
                    end else begin
                        unit_start <= U_ADD;
                    end
                end
                S_WAIT2: begin
                    if (unit_done[0]) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= add_res;
                    end else if (cnt == CNT_LAST) begin
                        state       <= S_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= 32'h0;
                        rsp_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - self-checking bench for fpu_issue_ctrl with unit stubs and reference model
module tb_fpu_issue_ctrl;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a, req_b, req_c;
    logic [4:0]  req_rd;
    logic [5:0]  unit_start;
    logic [4:0]  unit_op;
    logic [31:0] unit_a, unit_b;
    logic [5:0]  unit_done;
    logic [31:0] add_res, mul_res, sgnj_res, cvt_res, class_res, cmp_res;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_illegal;
    logic        rsp_timeout;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    fpu_issue_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_rd(req_rd),
        .unit_start(unit_start), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
        .unit_done(unit_done),
        .add_res(add_res), .mul_res(mul_res), .sgnj_res(sgnj_res),
        .cvt_res(cvt_res), .class_res(class_res), .cmp_res(cmp_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_illegal(rsp_illegal), .rsp_timeout(rsp_timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Reference: which unit owns each op code (one-hot, 0 = illegal)
    function automatic logic [5:0] ref_unit(input logic [4:0] op);
        int v;
        v = int'(op);
        if (v inside {10, 11})             return 6'd1;
        if (v inside {12, 13, 30, 31})     return 6'd2;
        if (v inside {17, 18, 19})         return 6'd4;
        if (v inside {22, 23, 25, 26})     return 6'd8;
        if (v == 24)                       return 6'd16;
        if (v inside {20, 21, 27, 28, 29}) return 6'd32;
        return 6'd0;
    endfunction

    task automatic drive_results(input logic [5:0] which, input logic [31:0] val);
        add_res   = which[0] ? val : $urandom;
        mul_res   = which[1] ? val : $urandom;
        sgnj_res  = which[2] ? val : $urandom;
        cvt_res   = which[3] ? val : $urandom;
        class_res = which[4] ? val : $urandom;
        cmp_res   = which[5] ? val : $urandom;
    endtask

    // One full op: request, stub units (k=0 means the unit never answers), response, hold, handshake
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [4:0] rd,
                          input int k1, input int k2,
                          input logic [31:0] r1, input logic [31:0] r2, input int hold);
        logic [5:0]  eu;
        logic        fused, legal;
        int          t0, s1, s2, rc, done_at, starts;
        int          exp_lat, exp_starts;
        logic [31:0] exp_data;
        logic        exp_tmo;
        logic [5:0]  done_bit, cur_bit;
        logic [31:0] done_val;
        logic [31:0] h_data;

        eu    = ref_unit(op);
        legal = (eu != 6'd0);
        fused = (op == 5'd30) || (op == 5'd31);
        if (!legal) begin
            exp_lat = 1; exp_starts = 0; exp_data = 32'h0; exp_tmo = 1'b0;
        end else if (k1 == 0) begin
            exp_lat = 2 + TMO; exp_starts = 1; exp_data = 32'h0; exp_tmo = 1'b1;
        end else if (!fused) begin
            exp_lat = 2 + k1; exp_starts = 1; exp_data = r1; exp_tmo = 1'b0;
        end else if (k2 == 0) begin
            exp_lat = 4 + k1 + TMO; exp_starts = 2; exp_data = 32'h0; exp_tmo = 1'b1;
        end else begin
            exp_lat = 4 + k1 + k2; exp_starts = 2; exp_data = r2; exp_tmo = 1'b0;
        end

        t0 = cyc; s1 = -1; s2 = -1; rc = -1; done_at = -1; starts = 0;
        done_bit = 6'd0; done_val = 32'h0;
        chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_c = c; req_rd = rd;
        rsp_ready = 1'b0;
        unit_done = 6'd0;
        drive_results(6'd0, 32'h0);
        step();
        req_valid = 1'b0;
        while (rc < 0 && (cyc - t0) < 300) begin
            if (unit_start != 6'd0) begin
                starts++;
                if (starts == 1) begin
                    s1 = cyc;
                    chk("start1_onehot", {26'h0, unit_start}, {26'h0, eu});
                    chk("start1_op", {27'h0, unit_op}, fused ? 32'd12 : {27'h0, op});
                    chk("start1_a", unit_a, a);
                    chk("start1_b", unit_b, b);
                    if (k1 > 0) begin done_at = cyc + k1; done_bit = eu; done_val = r1; end
                end else begin
                    s2 = cyc;
                    chk("start2_onehot", {26'h0, unit_start}, 32'h1);
                    chk("start2_op", {27'h0, unit_op}, (op == 5'd30) ? 32'd10 : 32'd11);
                    chk("start2_a", unit_a, r1);
                    chk("start2_b", unit_b, c);
                    if (k2 > 0) begin done_at = cyc + k2; done_bit = 6'd1; done_val = r2; end
                end
            end
            if (rsp_valid) begin
                rc = cyc;
            end else begin
                chk("inflight_busy_ready", {30'h0, busy, req_ready}, 32'h2);
                cur_bit   = (starts >= 2) ? 6'd1 : eu;
                unit_done = 6'($urandom) & ~cur_bit;
                if (cyc == done_at) begin
                    unit_done = unit_done | done_bit;
                    drive_results(done_bit, done_val);
                end else begin
                    drive_results(6'd0, 32'h0);
                end
                step();
            end
        end
        chk("rsp_seen", (rc >= 0) ? 32'h1 : 32'h0, 32'h1);
        chk("rsp_latency", rc - t0, exp_lat);
        chk("start_count", starts, exp_starts);
        if (legal) chk("start1_cycle", s1 - t0, 1);
        if (exp_starts == 2) chk("start2_cycle", s2 - t0, 3 + k1);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_rd", {27'h0, rsp_rd}, {27'h0, rd});
        chk("rsp_flags", {30'h0, rsp_illegal, rsp_timeout}, {30'h0, !legal, exp_tmo});
        chk("rsp_ready_low", {31'h0, req_ready}, 32'h0);

        h_data = rsp_data;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_op    = 5'($urandom);
            req_a     = $urandom;
            unit_done = 6'($urandom);
            drive_results(6'd0, 32'h0);
            step();
            chk("hold_stable", {rsp_data ^ h_data}, 32'h0);
            chk("hold_ctl", {24'h0, rsp_valid, req_ready, unit_start},
                {24'h0, 1'b1, 1'b0, 6'd0});
            chk("hold_rd_flags", {25'h0, rsp_rd, rsp_illegal, rsp_timeout},
                {25'h0, rd, !legal, exp_tmo});
        end
        req_valid = 1'b0;
        unit_done = 6'd0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("after_hs", {29'h0, rsp_valid, req_ready, busy}, {29'h0, 3'b010});
    endtask

    initial begin
        int k1, k2, hold;
        logic [4:0] op;

        rst = 1'b1; req_valid = 1'b0; req_op = 5'd0; req_a = 32'h0; req_b = 32'h0;
        req_c = 32'h0; req_rd = 5'd0; unit_done = 6'd0; rsp_ready = 1'b0;
        drive_results(6'd0, 32'h0);
        repeat (3) step();
        rst = 1'b0;
        chk("reset_ready_busy", {30'h0, req_ready, busy}, 32'h2);
        chk("reset_rsp", {23'h0, rsp_valid, rsp_illegal, rsp_timeout, rsp_rd, 1'b0}, 32'h0);
        chk("reset_data", rsp_data, 32'h0);
        chk("reset_unit", {21'h0, unit_start, unit_op}, 32'h0);
        chk("reset_ab", unit_a | unit_b, 32'h0);
        step();

        // Directed: ADD, fmadd, illegal, CMP timeout, long backpressure
        run_op(5'b01010, 32'h3F800000, 32'h40000000, 32'h0, 5'd7, 3, 0, 32'h40400000, 32'h0, 0);
        run_op(5'b11110, 32'h40000000, 32'h40400000, 32'h3F800000, 5'd9, 2, 3,
               32'h40C00000, 32'h40E00000, 1);
        run_op(5'b00111, 32'h12345678, 32'h9ABCDEF0, 32'h0, 5'd3, 1, 0, 32'hDEADBEEF, 32'h0, 0);
        run_op(5'b11101, 32'h1, 32'h2, 32'h0, 5'd17, 0, 0, 32'hDEADBEEF, 32'h0, 0);
        run_op(5'b11000, 32'h7F800000, 32'h0, 32'h0, 5'd31, 1, 0, 32'h00000080, 32'h0, 10);
        run_op(5'b01101, 32'h3, 32'h4, 32'h0, 5'd1, TMO, 0, 32'hCAFEF00D, 32'h0, 0);
        run_op(5'b11111, 32'h5, 32'h6, 32'h7, 5'd2, 1, 0, 32'hA5A5A5A5, 32'h0, 0);

        // Directed: reset while a MUL op sits in WAIT, then a late done
        chk("pre_rst_ready", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_op = 5'b01100; req_a = 32'h11; req_b = 32'h22; req_rd = 5'd5;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("mid_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_ready_busy", {30'h0, req_ready, busy}, 32'h2);
        chk("rst_mid_rsp", {24'h0, rsp_valid, rsp_illegal, rsp_timeout, rsp_rd}, 32'h0);
        chk("rst_mid_data", rsp_data, 32'h0);
        chk("rst_mid_unit", {21'h0, unit_start, unit_op}, 32'h0);
        chk("rst_mid_ab", unit_a | unit_b, 32'h0);
        unit_done = 6'b000010;
        drive_results(6'b000010, 32'h55555555);
        step();
        unit_done = 6'd0;
        for (int i = 0; i < 4; i++) begin
            chk("late_done_ignored", {29'h0, rsp_valid, busy, |unit_start}, 32'h0);
            step();
        end

        // Randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            op   = 5'($urandom);
            k1   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            k2   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            hold = int'($urandom_range(0, 3));
            run_op(op, $urandom, $urandom, $urandom, 5'($urandom), k1, k2,
                   $urandom, $urandom, hold);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
